// File: rtl/ant_readback.sv
// Ant readback sweep: scans every ant, captures {id, holding, X, Y} and hands each word out over a valid/ready port.
// Optional feature macro ANT_READBACK_FILTER_EN: emit only ants that are holding sugar.
module ant_readback #(
    parameter int ANT_num      = 16,
    parameter int ANT_num_bits = 4,
    parameter int X_bits       = 8,
    parameter int Y_bits       = 7
) (
    input  logic                                    Clk,
    input  logic                                    Reset_n,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic [ANT_num*X_bits-1:0]               Ant_X,
    input  logic [ANT_num*Y_bits-1:0]               Ant_Y,
    input  logic [ANT_num-1:0]                      Ant_holding_sugar,
    output logic                                    rd_valid,
    input  logic                                    rd_ready,
    output logic [ANT_num_bits+X_bits+Y_bits:0]     rd_data,
    output logic                                    busy,
    output logic                                    done,
    output logic [ANT_num_bits:0]                   word_count
);

    localparam int W = ANT_num_bits + 1 + X_bits + Y_bits;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [W-1:0] pack_word(input logic [ANT_num_bits-1:0] id,
                                               input logic                    hold,
                                               input logic [X_bits-1:0]       x,
                                               input logic [Y_bits-1:0]       y);
        return {id, hold, x, y};
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [ANT_num_bits-1:0] index_r, index_nxt_s;
    logic [ANT_num_bits:0]   count_r, count_nxt_s;
    logic [W-1:0]            data_r, data_nxt_s;
    logic                    valid_r, valid_nxt_s;
    logic                    busy_r, done_r;
    logic [X_bits-1:0]       x_sel_s;
    logic [Y_bits-1:0]       y_sel_s;
    logic                    hold_sel_s;
    logic                    last_s;
    logic                    xfer_s;

    assign x_sel_s    = Ant_X[int'(index_r)*X_bits +: X_bits];
    assign y_sel_s    = Ant_Y[int'(index_r)*Y_bits +: Y_bits];
    assign hold_sel_s = Ant_holding_sugar[index_r];
    assign last_s     = (index_r == ANT_num_bits'(ANT_num - 1));
    assign xfer_s     = valid_r && rd_ready;

    // Next-state, index, counter and output-word decode
    always_comb begin
        state_nxt_s = state_r;
        index_nxt_s = index_r;
        count_nxt_s = count_r;
        data_nxt_s  = data_r;
        valid_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                // abort beats a simultaneous start
                if (start && !abort) begin
                    index_nxt_s = '0;
                    count_nxt_s = '0;
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt_s = IDLE;
`ifdef ANT_READBACK_FILTER_EN
                end else if (!hold_sel_s) begin
                    if (last_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        index_nxt_s = index_r + ANT_num_bits'(1);
                        state_nxt_s = LOAD;
                    end
`endif
                end else begin
                    data_nxt_s  = pack_word(index_r, hold_sel_s, x_sel_s, y_sel_s);
                    valid_nxt_s = 1'b1;
                    state_nxt_s = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (xfer_s) begin
                    count_nxt_s = count_r + (ANT_num_bits + 1)'(1);
                    if (last_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        index_nxt_s = index_r + ANT_num_bits'(1);
                        state_nxt_s = LOAD;
                    end
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by Reset_n
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
            index_r <= '0;
            count_r <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            index_r <= index_nxt_s;
            count_r <= count_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    assign rd_valid   = valid_r;
    assign rd_data    = data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign word_count = count_r;

endmodule

// File: tb/tb_ant_readback.sv
// Directed bench for ant_readback: expected words are queued when a sweep is started and popped on each transfer.
module tb_ant_readback;

    localparam int N  = 16;
    localparam int NB = 4;
    localparam int XB = 8;
    localparam int YB = 7;
    localparam int W  = NB + 1 + XB + YB;
`ifdef ANT_READBACK_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              rd_ready = 1'b1;
    logic [N*XB-1:0]   Ant_X;
    logic [N*YB-1:0]   Ant_Y;
    logic [N-1:0]      Ant_holding_sugar;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic [W-1:0]      rd_data;
    logic [NB:0]       word_count;

    int           n_tests = 0;
    int           n_fail = 0;
    int           exp_cnt = 0;
    logic [W-1:0] sb_q[$];

    always #5 Clk = ~Clk;

    ant_readback #(.ANT_num(N), .ANT_num_bits(NB), .X_bits(XB), .Y_bits(YB)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
        .Ant_X(Ant_X), .Ant_Y(Ant_Y), .Ant_holding_sugar(Ant_holding_sugar),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .word_count(word_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ants(input logic [N-1:0] hold);
        for (int i = 0; i < N; i++) begin
            Ant_X[i*XB +: XB] = XB'(i + 10);
            Ant_Y[i*YB +: YB] = YB'(i + 3);
        end
        Ant_holding_sugar = hold;
    endtask

    function automatic logic [W-1:0] word_of(input int i);
        logic [NB-1:0] id;
        id = NB'(i);
        return {id, Ant_holding_sugar[i], Ant_X[i*XB +: XB], Ant_Y[i*YB +: YB]};
    endfunction

    // Queue the expected words, then start and check the two-edge latency
    task automatic begin_sweep();
        exp_cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (!FILT || Ant_holding_sugar[i]) begin
                sb_q.push_back(word_of(i));
                exp_cnt++;
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("lat_edge1_valid", rd_valid, 0);
        chk("lat_edge1_busy", busy, 1);
        step();
`ifndef ANT_READBACK_FILTER_EN
        chk("lat_edge2_valid", rd_valid, 1);
`endif
    endtask

    task automatic collect(input int stop_after, input int stall_id, input int stall_len,
                           input int busy_start_at, input bit spacing, output int xfers,
                           output logic [W-1:0] first_w, output logic [W-1:0] last_w,
                           output bit done_seen);
        int           stalled;
        int           last_cyc;
        logic [W-1:0] exp_w;
        stalled = 0;
        last_cyc = -1;
        xfers = 0;
        done_seen = 1'b0;
        first_w = '0;
        last_w = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            start = (cyc == busy_start_at);
            rd_ready = 1'b1;
            if (rd_valid) begin
                exp_w = (sb_q.size() > 0) ? sb_q[0] : 'x;
                if (rd_data[W-1 -: NB] == NB'(stall_id) && stalled < stall_len) begin
                    rd_ready = 1'b0;
                    stalled++;
                    chk("stall_hold", rd_data, exp_w);
                end else begin
                    chk("word", rd_data, exp_w);
                    if (sb_q.size() > 0) exp_w = sb_q.pop_front();
                    if (xfers == 0) first_w = rd_data;
                    last_w = rd_data;
                    if (spacing && last_cyc >= 0) chk("spacing", cyc - last_cyc, 2);
                    last_cyc = cyc;
                    xfers++;
                end
            end
            step();
            if (xfers == stop_after) break;
        end
        start = 1'b0;
        rd_ready = 1'b1;
    endtask

    task automatic finish_checks(input bit done_seen);
        chk("done_pulse", done_seen, 1);
        chk("wc_sweep", word_count, exp_cnt);
        chk("sb_empty", sb_q.size(), 0);
        step();
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("wc_hold", word_count, exp_cnt);
    endtask

    initial begin
        int           xf;
        int           edges;
        logic [W-1:0] fw;
        logic [W-1:0] lw;
        bit           ds;

        set_ants(16'hAAAA);
        #2;
        chk("rst_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_wc", word_count, 0);
        #10 Reset_n = 1'b1;
        step();

        // basic sweep, ready always high
        begin_sweep();
        collect(-1, -1, 0, -1, !FILT, xf, fw, lw, ds);
`ifndef ANT_READBACK_FILTER_EN
        chk("first_word", fw, {4'd0, 1'b0, 8'd10, 7'd3});
        chk("last_word", lw, {4'd15, 1'b1, 8'd25, 7'd18});
        chk("wc_16", word_count, 16);
`endif
        finish_checks(ds);

        // backpressure on word 3
        begin_sweep();
        collect(-1, 3, 5, -1, 1'b0, xf, fw, lw, ds);
        finish_checks(ds);

        // start pulsed while busy must be ignored
        begin_sweep();
        collect(-1, -1, 0, 7, 1'b0, xf, fw, lw, ds);
        finish_checks(ds);
        step();
        chk("no_restart", busy, 0);

        // abort after the fourth transfer
        begin_sweep();
        collect(4, -1, 0, -1, 1'b0, xf, fw, lw, ds);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_valid", rd_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_wc", word_count, 4);
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_done", done, 0);
            step();
        end
        sb_q.delete();

        // abort wins over start in IDLE
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_idle", busy, 0);
        step();
        chk("abort_start_idle2", busy, 0);

        // asynchronous reset mid-sweep, then a full sweep
        begin_sweep();
        collect(2, -1, 0, -1, 1'b0, xf, fw, lw, ds);
        step();
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_wc", word_count, 0);
        sb_q.delete();
        #3 Reset_n = 1'b1;
        step();
        chk("arst_idle", busy, 0);
        begin_sweep();
        collect(-1, -1, 0, -1, 1'b0, xf, fw, lw, ds);
        finish_checks(ds);

`ifdef ANT_READBACK_FILTER_EN
        // only ants 2 and 15 hold sugar
        set_ants(16'h8004);
        begin_sweep();
        collect(-1, -1, 0, -1, 1'b0, xf, fw, lw, ds);
        chk("filt_first_id", fw[W-1 -: NB], 2);
        chk("filt_last_id", lw[W-1 -: NB], 15);
        chk("filt_xfers", xf, 2);
        finish_checks(ds);

        // nobody holds sugar: done after ANT_num+1 edges counting the start edge
        set_ants('0);
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 1;
        while (!done && edges < 40) begin
            step();
            edges++;
        end
        chk("nohold_latency", edges, N + 1);
        chk("nohold_wc", word_count, 0);
        chk("nohold_valid", rd_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
